// File: rtl/jk_bank_driver.sv
// Drives the J/K inputs of an external JK flip-flop bank toward a commanded target,
// then verifies the Q readback with bounded re-drive and a sticky error on persistent mismatch.
module jk_bank_driver #(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iCmdValid,
    input  logic [1:0]       iCmd,
    input  logic [WIDTH-1:0] iData,
    output logic             oCmdReady,
    input  logic [WIDTH-1:0] iQ,
    output logic [WIDTH-1:0] oJ,
    output logic [WIDTH-1:0] oK,
    output logic             oDone,
    output logic             oErr,
    output logic [WIDTH-1:0] oExpected,
    input  logic             iClrErr
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] maxRetry = RW'(MAX_RETRY);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, ERROR} stateT;

    stateT            state;
    stateT            nextState;
    logic [RW-1:0]    retryCnt;
    logic [WIDTH-1:0] target;
    logic             match;
    logic             retryLeft;
    logic             accept;

    // Excitation never produces the toggle code: set only bits rising, reset only bits falling.
    function automatic logic [WIDTH-1:0] exciteJ(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
        return ~q & t;
    endfunction

    function automatic logic [WIDTH-1:0] exciteK(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] t);
        return q & ~t;
    endfunction

    always_comb begin
        target = iQ;
        case (iCmd)
            2'b00:   target = iQ;
            2'b01:   target = iData;
            2'b10:   target = iQ + WIDTH'(1);
            default: target = iQ - WIDTH'(1);
        endcase
    end

    assign match     = (iQ == oExpected);
    assign retryLeft = (retryCnt < maxRetry);
    assign accept    = (state == IDLE) && iCmdValid;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (iCmdValid) nextState = DRIVE;
            DRIVE:   nextState = CHECK;
            CHECK:   begin
                if (match) begin
                    nextState = IDLE;
                end else if (retryLeft) begin
                    nextState = DRIVE;
                end else begin
                    nextState = ERROR;
                end
            end
            ERROR:   if (iClrErr) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        oCmdReady = (state == IDLE);
    end

    // J/K fall back to the hold code every cycle unless a drive is being launched.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            oJ        <= '0;
            oK        <= '0;
            oDone     <= 1'b0;
            oErr      <= 1'b0;
            oExpected <= '0;
            retryCnt  <= '0;
        end else begin
            oJ    <= '0;
            oK    <= '0;
            oDone <= 1'b0;
            if (accept) begin
                oExpected <= target;
                oJ        <= exciteJ(iQ, target);
                oK        <= exciteK(iQ, target);
                retryCnt  <= '0;
            end
            if (state == CHECK) begin
                if (match) begin
                    oDone <= 1'b1;
                end else if (retryLeft) begin
                    retryCnt <= retryCnt + RW'(1);
                    oJ       <= exciteJ(iQ, oExpected);
                    oK       <= exciteK(iQ, oExpected);
                end else begin
                    oErr <= 1'b1;
                end
            end
            if ((state == ERROR) && iClrErr) begin
                oErr <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Self-checking bench for jk_bank_driver with a behavioural JK bank on the same clock.
module tb_jk_bank_driver;

    logic       iClk = 1'b0;
    logic       iRst = 1'b1;
    logic       iCmdValid = 1'b0;
    logic [1:0] iCmd = 2'b00;
    logic [3:0] iData = 4'h0;
    logic       oCmdReady;
    logic [3:0] oJ;
    logic [3:0] oK;
    logic       oDone;
    logic       oErr;
    logic [3:0] oExpected;
    logic       iClrErr = 1'b0;

    logic [3:0] bankQ = 4'h0;
    logic       preloadEn = 1'b0;
    logic [3:0] preloadVal = 4'h0;
    logic [3:0] forceLow = 4'h0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [1:0] cmd;
        logic [3:0] data;
        logic [3:0] startQ;
        logic [3:0] expTarget;
        logic [3:0] expJ;
        logic [3:0] expK;
    } vecT;

    vecT vecs[7];

    jk_bank_driver #(.WIDTH(4), .MAX_RETRY(2)) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iCmdValid (iCmdValid),
        .iCmd      (iCmd),
        .iData     (iData),
        .oCmdReady (oCmdReady),
        .iQ        (bankQ),
        .oJ        (oJ),
        .oK        (oK),
        .oDone     (oDone),
        .oErr      (oErr),
        .oExpected (oExpected),
        .iClrErr   (iClrErr)
    );

    always #5 iClk = ~iClk;

    // Ideal JK bank; forceLow models stuck-at-0 cells.
    always @(posedge iClk) begin
        if (preloadEn) begin
            bankQ <= preloadVal & ~forceLow;
        end else begin
            bankQ <= ((oJ & ~bankQ) | (~oK & bankQ)) & ~forceLow;
        end
    end

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic preload(input logic [3:0] v);
        preloadEn  = 1'b1;
        preloadVal = v;
        tick();
        preloadEn  = 1'b0;
    endtask

    // Presents a command for one accept edge and leaves the DUT in DRIVE.
    task automatic applyStimulus(input logic [1:0] cmd, input logic [3:0] data);
        iCmdValid = 1'b1;
        iCmd      = cmd;
        iData     = data;
        tick();
        iCmdValid = 1'b0;
        iData     = 4'h0;
    endtask

    function automatic logic [3:0] modelTarget(input logic [1:0] cmd, input logic [3:0] q, input logic [3:0] d);
        case (cmd)
            2'b00:   return q;
            2'b01:   return d;
            2'b10:   return q + 4'd1;
            default: return q - 4'd1;
        endcase
    endfunction

    initial begin
        int doneCount;
        bit doneSeen;
        bit overlap;
        logic [1:0] rCmd;
        logic [3:0] rData;
        logic [3:0] rExp;

        vecs[0] = '{cmd: 2'b01, data: 4'b1010, startQ: 4'b0000, expTarget: 4'b1010, expJ: 4'b1010, expK: 4'b0000};
        vecs[1] = '{cmd: 2'b10, data: 4'b0000, startQ: 4'b1111, expTarget: 4'b0000, expJ: 4'b0000, expK: 4'b1111};
        vecs[2] = '{cmd: 2'b11, data: 4'b0000, startQ: 4'b0000, expTarget: 4'b1111, expJ: 4'b1111, expK: 4'b0000};
        vecs[3] = '{cmd: 2'b00, data: 4'b1001, startQ: 4'b0110, expTarget: 4'b0110, expJ: 4'b0000, expK: 4'b0000};
        vecs[4] = '{cmd: 2'b10, data: 4'b0000, startQ: 4'b0111, expTarget: 4'b1000, expJ: 4'b1000, expK: 4'b0111};
        vecs[5] = '{cmd: 2'b11, data: 4'b1111, startQ: 4'b1000, expTarget: 4'b0111, expJ: 4'b0111, expK: 4'b1000};
        vecs[6] = '{cmd: 2'b01, data: 4'b0011, startQ: 4'b1100, expTarget: 4'b0011, expJ: 4'b0011, expK: 4'b1100};

        tick();
        tick();
        iRst = 1'b0;
        checkOutput("reset oJ", 32'(oJ), 32'h0);
        checkOutput("reset oK", 32'(oK), 32'h0);
        checkOutput("reset oDone", 32'(oDone), 32'h0);
        checkOutput("reset oErr", 32'(oErr), 32'h0);
        checkOutput("reset oExpected", 32'(oExpected), 32'h0);
        checkOutput("reset oCmdReady", 32'(oCmdReady), 32'h1);

        // Directed vectors: exact drive codes and 3-cycle accept-to-done latency.
        for (int i = 0; i < 7; i++) begin
            preload(vecs[i].startQ);
            applyStimulus(vecs[i].cmd, vecs[i].data);
            checkOutput($sformatf("vec%0d drive oJ", i), 32'(oJ), 32'(vecs[i].expJ));
            checkOutput($sformatf("vec%0d drive oK", i), 32'(oK), 32'(vecs[i].expK));
            checkOutput($sformatf("vec%0d oExpected", i), 32'(oExpected), 32'(vecs[i].expTarget));
            checkOutput($sformatf("vec%0d drive ready", i), 32'(oCmdReady), 32'h0);
            tick();
            checkOutput($sformatf("vec%0d check oJ", i), 32'(oJ), 32'h0);
            checkOutput($sformatf("vec%0d check oDone", i), 32'(oDone), 32'h0);
            tick();
            checkOutput($sformatf("vec%0d oDone", i), 32'(oDone), 32'h1);
            checkOutput($sformatf("vec%0d bankQ", i), 32'(bankQ), 32'(vecs[i].expTarget));
            checkOutput($sformatf("vec%0d ready", i), 32'(oCmdReady), 32'h1);
            tick();
            checkOutput($sformatf("vec%0d oDone drop", i), 32'(oDone), 32'h0);
        end

        // Stuck-at-0 bit 0: initial drive plus two retries, then sticky error.
        forceLow = 4'b0001;
        preload(4'b0000);
        iClrErr = 1'b1;
        applyStimulus(2'b01, 4'b0001);
        iClrErr = 1'b0;
        for (int r = 0; r < 3; r++) begin
            checkOutput($sformatf("retry%0d oJ", r), 32'(oJ), 32'h1);
            checkOutput($sformatf("retry%0d oK", r), 32'(oK), 32'h0);
            tick();
            checkOutput($sformatf("retry%0d check oErr", r), 32'(oErr), 32'h0);
            tick();
        end
        checkOutput("error oErr", 32'(oErr), 32'h1);
        checkOutput("error oDone", 32'(oDone), 32'h0);
        checkOutput("error ready", 32'(oCmdReady), 32'h0);
        iCmdValid = 1'b1;
        tick();
        tick();
        iCmdValid = 1'b0;
        checkOutput("error sticky", 32'(oErr), 32'h1);
        checkOutput("error oJ", 32'(oJ), 32'h0);
        iClrErr = 1'b1;
        tick();
        iClrErr = 1'b0;
        checkOutput("clear oErr", 32'(oErr), 32'h0);
        checkOutput("clear ready", 32'(oCmdReady), 32'h1);
        forceLow = 4'b0000;

        // Commands presented while busy must be dropped.
        preload(4'b0000);
        applyStimulus(2'b01, 4'b0011);
        iCmdValid = 1'b1;
        iCmd      = 2'b01;
        iData     = 4'b0101;
        tick();
        tick();
        iCmdValid = 1'b0;
        doneCount = oDone ? 1 : 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (oDone) doneCount++;
        end
        checkOutput("busy ignore doneCount", 32'(doneCount), 32'h1);
        checkOutput("busy ignore bankQ", 32'(bankQ), 32'h3);
        checkOutput("busy ignore oExpected", 32'(oExpected), 32'h3);

        // Asynchronous reset in the middle of DRIVE.
        preload(4'b0000);
        applyStimulus(2'b01, 4'b1111);
        #2;
        iRst = 1'b1;
        #1;
        checkOutput("async rst oJ", 32'(oJ), 32'h0);
        checkOutput("async rst oK", 32'(oK), 32'h0);
        checkOutput("async rst oDone", 32'(oDone), 32'h0);
        checkOutput("async rst oErr", 32'(oErr), 32'h0);
        checkOutput("async rst oExpected", 32'(oExpected), 32'h0);
        checkOutput("async rst ready", 32'(oCmdReady), 32'h1);
        tick();
        iRst = 1'b0;
        tick();

        // Random commands against the ideal bank.
        for (int n = 0; n < 1000; n++) begin
            rCmd  = 2'($urandom_range(0, 3));
            rData = 4'($urandom);
            rExp  = modelTarget(rCmd, bankQ, rData);
            applyStimulus(rCmd, rData);
            doneSeen = 1'b0;
            overlap  = 1'b0;
            for (int c = 0; c < 10 && !doneSeen; c++) begin
                if ((oJ & oK) != 4'h0) overlap = 1'b1;
                if (oDone && oErr) overlap = 1'b1;
                tick();
                if (oDone) doneSeen = 1'b1;
            end
            checkOutput($sformatf("rand%0d done", n), 32'(doneSeen), 32'h1);
            checkOutput($sformatf("rand%0d no toggle", n), 32'(overlap), 32'h0);
            checkOutput($sformatf("rand%0d oExpected", n), 32'(oExpected), 32'(rExp));
            checkOutput($sformatf("rand%0d bankQ", n), 32'(bankQ), 32'(rExp));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
